// File: rtl/picture_bank_ctrl.sv
// Picture bank controller: a 35-pixel (5x7) working frame, four save slots,
// row-serial CLEAR/SAVE/LOAD/INVERT commands and a multiplexed row scanner.
module picture_bank_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        place,
  input  logic [34:0] ens_cursor,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_slot,
  output logic        cmd_ready,
  output logic        done,
  output logic [34:0] picture,
  output logic [4:0]  row_sel,
  output logic [6:0]  col_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_SAVE   = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_INVERT = 2'b11;

  localparam int              CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic [1:0]       r_state;
  logic [34:0]      r_work;
  logic [34:0]      r_slot [4];
  logic             r_pend;
  logic [34:0]      r_mask;
  logic [1:0]       r_op;
  logic [1:0]       r_sel;
  logic [2:0]       r_row;
  logic [CNT_W-1:0] r_scan;
  logic [4:0]       r_row_sel;

  logic             w_accept;
  logic [5:0]       w_base;
  logic [6:0]       w_work_row;
  logic [6:0]       w_slot_row;

  // New working-row value for the row-serial commands that write the frame.
  function automatic logic [6:0] row_op(input logic [1:0] op,
                                        input logic [6:0] work_row,
                                        input logic [6:0] slot_row);
    case (op)
      OP_CLEAR:  row_op = '0;
      OP_LOAD:   row_op = slot_row;
      OP_INVERT: row_op = ~work_row;
      default:   row_op = work_row;
    endcase
  endfunction

  assign cmd_ready  = (r_state == S_IDLE) && !r_pend;
  assign w_accept   = cmd_valid && cmd_ready;
  assign done       = (r_state == S_DONE);
  assign picture    = r_work;
  assign row_sel    = r_row_sel;
  assign w_base     = 6'(r_row) * 6'd7;
  assign w_work_row = r_work[w_base +: 7];
  assign w_slot_row = r_slot[r_sel][w_base +: 7];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      for (int i = 0; i < 4; i++) r_slot[i] <= '0;
      r_pend  <= 1'b0;
      r_mask  <= '0;
      r_op    <= OP_CLEAR;
      r_sel   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A toggle deferred from a busy period wins over any new place pulse.
          if (r_pend) begin
            r_work <= r_work ^ r_mask;
            r_pend <= 1'b0;
          end else if (place) begin
            r_work <= r_work ^ ens_cursor;
          end
          if (w_accept) begin
            r_state <= S_RUN;
            r_op    <= cmd_op;
            r_sel   <= cmd_slot;
            r_row   <= '0;
          end
        end
        S_RUN: begin
          if (r_op == OP_SAVE) r_slot[r_sel][w_base +: 7] <= w_work_row;
          else                 r_work[w_base +: 7]        <= row_op(r_op, w_work_row, w_slot_row);
          if (r_row == 3'd4) r_state <= S_DONE;
          else               r_row   <= r_row + 3'd1;
          if (place && !r_pend) begin
            r_pend <= 1'b1;
            r_mask <= ens_cursor;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (place && !r_pend) begin
            r_pend <= 1'b1;
            r_mask <= ens_cursor;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Display scan: one row per SCAN_DIV clocks, rotating left.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_scan    <= '0;
      r_row_sel <= 5'b00001;
    end else if (r_scan == SCAN_LAST) begin
      r_scan    <= '0;
      r_row_sel <= {r_row_sel[3:0], r_row_sel[4]};
    end else begin
      r_scan    <= r_scan + 1'b1;
    end
  end

  always_comb begin
    col_data = '0;
    case (r_row_sel)
      5'b00001: col_data = r_work[6:0];
      5'b00010: col_data = r_work[13:7];
      5'b00100: col_data = r_work[20:14];
      5'b01000: col_data = r_work[27:21];
      5'b10000: col_data = r_work[34:28];
      default:  col_data = '0;
    endcase
  end

endmodule

// File: tb/tb_picture_bank_ctrl.sv
// Directed bench for picture_bank_ctrl; command results are queued on issue
// and checked when the done pulse appears.
module tb_picture_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        place;
  logic [34:0] ens_cursor;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_slot;
  logic        cmd_ready;
  logic        done;
  logic [34:0] picture;
  logic [4:0]  row_sel;
  logic [6:0]  col_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] exp_q [$];

  localparam logic [34:0] ALL1 = 35'h7FFFFFFFF;
  localparam logic [34:0] BIT0 = 35'h1;
  localparam logic [34:0] B34  = 35'h400000000;
  localparam logic [34:0] ROW1 = 35'h55 << 7;

  picture_bank_ctrl #(.SCAN_DIV(4)) dut (
    .CLOCK_50  (clk),
    .rst_n     (rst_n),
    .place     (place),
    .ens_cursor(ens_cursor),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_slot  (cmd_slot),
    .cmd_ready (cmd_ready),
    .done      (done),
    .picture   (picture),
    .row_sel   (row_sel),
    .col_data  (col_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_place(input logic [34:0] mask);
    place = 1'b1;
    ens_cursor = mask;
    tick();
    place = 1'b0;
    ens_cursor = '0;
  endtask

  // Issues one command and follows it to cycle 7 after the acceptance edge.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] slot,
                        input logic [34:0] exp_pic, input bit hold,
                        input int pa_cyc, input logic [34:0] pa_mask,
                        input int pb_cyc, input logic [34:0] pb_mask,
                        input logic exp_rdy7);
    int done_cyc;
    int n_done;
    logic [34:0] exp_v;
    done_cyc = 0;
    n_done   = 0;
    exp_q.push_back(exp_pic);
    check({tag, "_ready_pre"}, 35'(cmd_ready), 35'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_slot  = slot;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin
        if (done) begin
          n_done++;
          if (done_cyc == 0) done_cyc = c;
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check({tag, "_picture"}, picture, exp_v);
          end else begin
            check({tag, "_queue_nonempty"}, 35'(0), 35'(1));
          end
        end
        if (c <= 6) check($sformatf("%s_ready_c%0d", tag, c), 35'(cmd_ready), 35'(0));
        else        check({tag, "_ready_c7"}, 35'(cmd_ready), 35'(exp_rdy7));
      end
      if (c == pa_cyc) begin
        place = 1'b1; ens_cursor = pa_mask;
      end else if (c == pb_cyc) begin
        place = 1'b1; ens_cursor = pb_mask;
      end else begin
        place = 1'b0; ens_cursor = '0;
      end
      if (c < 7) begin
        tick();
        if (c == 0 && !hold) cmd_valid = 1'b0;
      end
    end
    place = 1'b0;
    ens_cursor = '0;
    check({tag, "_done_cycle"}, 35'(done_cyc), 35'(6));
    check({tag, "_done_count"}, 35'(n_done), 35'(1));
  endtask

  initial begin
    rst_n = 1'b0; place = 1'b0; ens_cursor = '0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_slot = 2'b00;
    repeat (2) tick();
    check("rst_picture", picture, 35'(0));
    check("rst_done", 35'(done), 35'(0));
    check("rst_row_sel", 35'(row_sel), 35'(5'b00001));
    check("rst_col_data", 35'(col_data), 35'(0));

    // Release mid-cycle: this interval is cycle 0 of the scan.
    rst_n = 1'b1;
    check("post_rst_ready", 35'(cmd_ready), 35'(1));
    do_place(ROW1);
    check("row1_picture", picture, ROW1);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("scan_sel_c%0d", c), 35'(row_sel),
            35'((c < 4) ? 5'b00001 : (c < 8) ? 5'b00010 : 5'b00100));
      check($sformatf("scan_col_c%0d", c), 35'(col_data),
            35'((c >= 4 && c < 8) ? 7'b1010101 : 7'b0));
      if (c < 8) tick();
    end
    do_place(ROW1);
    check("row1_cleared", picture, 35'(0));

    do_place(BIT0);
    check("place_bit0", picture, BIT0);
    do_place(BIT0);
    check("place_bit0_again", picture, 35'(0));
    do_place(35'(0));
    check("place_zero_mask", picture, 35'(0));
    do_place(BIT0);

    do_cmd("save2",  2'b01, 2'd2, BIT0,   1'b0, -1, '0, -1, '0, 1'b1);
    do_cmd("clear",  2'b00, 2'd0, 35'(0), 1'b0, -1, '0, -1, '0, 1'b1);
    do_cmd("load2",  2'b10, 2'd2, BIT0,   1'b0, -1, '0, -1, '0, 1'b1);
    do_cmd("clear2", 2'b00, 2'd1, 35'(0), 1'b0, -1, '0, -1, '0, 1'b1);

    // Held cmd_valid: second INVERT is taken at the first IDLE cycle.
    do_cmd("inv_hold", 2'b11, 2'd0, ALL1,   1'b1, -1, '0, -1, '0, 1'b1);
    do_cmd("inv_back", 2'b11, 2'd0, 35'(0), 1'b0, -1, '0, -1, '0, 1'b1);

    // Place during RUN is deferred; the second pulse is dropped.
    do_cmd("inv_pend", 2'b11, 2'd0, ALL1, 1'b0, 2, B34, 3, BIT0, 1'b0);
    tick();
    check("pend_applied", picture, ALL1 ^ B34);
    check("pend_ready", 35'(cmd_ready), 35'(1));

    // Toggle and acceptance in the same cycle: command sees toggled frame.
    do_cmd("inv_sim", 2'b11, 2'd0, 35'(0), 1'b0, 0, B34, -1, '0, 1'b1);

    do_place(ALL1);
    do_cmd("save0", 2'b01, 2'd0, ALL1, 1'b0, -1, '0, -1, '0, 1'b1);

    // Reset asynchronously during row 2 of a LOAD.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_slot = 2'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_picture", picture, 35'(0));
    check("midrst_done", 35'(done), 35'(0));
    check("midrst_row_sel", 35'(row_sel), 35'(5'b00001));
    check("midrst_col_data", 35'(col_data), 35'(0));
    check("midrst_ready", 35'(cmd_ready), 35'(1));
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("midrst_hold_done_%0d", c), 35'(done), 35'(0));
    end
    rst_n = 1'b1;
    check("midrst_release_ready", 35'(cmd_ready), 35'(1));
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("midrst_no_done_%0d", c), 35'(done), 35'(0));
    end

    do_place(ALL1);
    do_cmd("load0_after_rst", 2'b10, 2'd0, 35'(0), 1'b0, -1, '0, -1, '0, 1'b1);
    do_place(ALL1);
    do_cmd("load3_after_rst", 2'b10, 2'd3, 35'(0), 1'b0, -1, '0, -1, '0, 1'b1);

    check("queue_drained", 35'(exp_q.size()), 35'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/picture_bank_ctrl.md
PICTURE_BANK_CTRL -- requirements
Module: picture_bank_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000: CLOCK_50 cycles per display row; legal range >= 2.
REQ-002 SHALL provide port CLOCK_50  input  1: sole clock, rising edge.
REQ-003 SHALL provide port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL provide port place  input  1: one-cycle request to toggle the pixels selected by ens_cursor.
REQ-005 SHALL provide port ens_cursor  input  35: pixel mask; bit 7*r+c is row r (0..4), column c (0..6).
REQ-006 SHALL provide port cmd_valid  input  1: bank command request.
REQ-007 SHALL provide port cmd_op  input  2: command code; 00 CLEAR, 01 SAVE, 10 LOAD, 11 INVERT.
REQ-008 SHALL provide port cmd_slot  input  2: slot index 0..3 for SAVE/LOAD; ignored for CLEAR/INVERT.
REQ-009 SHALL provide port cmd_ready  output  1: high when a command can be accepted.
REQ-010 SHALL provide port done  output  1: one-cycle pulse at command completion.
REQ-011 SHALL provide port picture  output  35: working frame, same bit mapping as ens_cursor.
REQ-012 SHALL provide port row_sel  output  5: one-hot active display row.
REQ-013 SHALL provide port col_data  output  7: working-frame bits of the active row.

Function
REQ-014 SHALL hold one 35-bit working frame plus four 35-bit slot frames in registers.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL drive cmd_ready = (state==IDLE) && !pend; a command is accepted on a cycle where cmd_valid && cmd_ready, latching cmd_op and cmd_slot.
REQ-017 SHALL go IDLE->RUN on acceptance; RUN processes one row per cycle with row counter 0..4; RUN->DONE after row 4; DONE->IDLE after one cycle.
REQ-018 SHALL assert done only during the DONE cycle, which is 6 cycles after the acceptance edge.
REQ-019 SHALL perform per RUN row r: CLEAR working row r = 0; SAVE slot[s] row r = working row r; LOAD working row r = slot[s] row r; INVERT working row r = ~working row r.
REQ-020 SHALL apply place in IDLE in the same cycle: working = working ^ ens_cursor.
REQ-021 SHALL, when place arrives in RUN or DONE, set pend=1 and latch ens_cursor; in the first IDLE cycle apply the latched mask and clear pend.
REQ-022 SHALL ignore further place pulses while pend=1; the first latched mask is kept.
REQ-023 SHALL, on simultaneous place and accepted command in IDLE, apply the toggle that cycle; the command then operates on the toggled frame.
REQ-024 SHALL make a zero mask a no-op and toggle every set bit of a multi-hot mask.
REQ-025 SHALL scan the display with a counter 0..SCAN_DIV-1; on wrap, row_sel rotates left (00001->00010->...->10000->00001).
REQ-026 SHALL drive col_data combinationally from the live working row chosen by row_sel, independent of FSM state.

Reset
REQ-027 SHALL, on rst_n low at any time (mid-RUN included), immediately clear: state to IDLE, working/slots/pend/row counter/scan counter to 0, done 0, row_sel 00001.
REQ-028 SHALL make cmd_ready 1 in the first cycle after rst_n deasserts.

Verification
REQ-029 SHALL cover: reset, place with ens_cursor=bit 0 -> picture=35'h1; repeated place -> 0.
REQ-030 SHALL cover: picture=35'h1, SAVE slot 2, then CLEAR, then LOAD slot 2 -> picture 0 after CLEAR done, 35'h1 after LOAD done; each done exactly 6 cycles after acceptance.
REQ-031 SHALL cover: INVERT from 0 -> picture=35'h7FFFFFFFF; cmd_ready low during RUN/DONE; cmd_valid held high is accepted again only on return to IDLE.
REQ-032 SHALL cover: place (mask bit 34) during RUN, then second place (bit 0) -> after IDLE only bit 34 toggled; cmd_ready low while pend=1.
REQ-033 SHALL cover: SCAN_DIV=4, picture row 1 = 7'b1010101 -> row_sel 00010 during cycles 4..7 after reset with col_data=1010101.
REQ-034 SHALL cover: rst_n pulled low in RUN row 2 of LOAD -> all outputs at reset values; the slot stays 0; no done pulse.
